// File: rtl/sad_stream_driver.sv
// Host-loaded operand store that streams A/B sample pairs into a SAD engine,
// collects the engine sum and cross-checks it against a locally computed shadow SAD.
module sad_stream_driver #(
  parameter int N_SAMPLES = 16,
  parameter int DW        = 8,
  parameter int RW        = 32,
  parameter int AW        = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start_i,
  output logic          ready_o,
  output logic          sad_enb_o,
  output logic [DW-1:0] sad_dta_o,
  output logic [DW-1:0] sad_dtb_o,
  input  logic          sad_busy_i,
  input  logic [RW-1:0] sad_dt_i,
  output logic          res_valid_o,
  output logic [RW-1:0] res_data_o,
  input  logic          res_ready_i,
  output logic          mism_o,
  output logic          err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, WAIT, HOLD} state_t;

  state_t        state;
  logic [DW-1:0] mem_a [N_SAMPLES];
  logic [DW-1:0] mem_b [N_SAMPLES];
  logic [AW-1:0] idx;
  logic [AW-1:0] nidx;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] shadow;
  logic [DW:0]   diff;
  logic [DW-1:0] a0;
  logic [DW-1:0] b0;
  logic          wr_ok;

  assign wr_ok = wr_en && (state == IDLE);
  assign nidx  = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
  end

  // A write to index 0 in the start cycle must reach the first pair on the bus.
  always_comb begin
    a0 = mem_a[0];
    b0 = mem_b[0];
    if (wr_ok && (wr_addr == '0)) begin
      if (wr_sel) b0 = wr_data;
      else        a0 = wr_data;
    end
  end

  // Shadow accumulates the pair currently driven on the bus.
  always_comb begin
    if (sad_dta_o >= sad_dtb_o) diff = {1'b0, sad_dta_o} - {1'b0, sad_dtb_o};
    else                        diff = {1'b0, sad_dtb_o} - {1'b0, sad_dta_o};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      sad_enb_o   <= 1'b0;
      sad_dta_o   <= '0;
      sad_dtb_o   <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      mism_o      <= 1'b0;
      err_o       <= 1'b0;
      idx         <= '0;
      tcnt        <= '0;
      shadow      <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b1;
          if (start_i) begin
            state     <= ISSUE;
            ready_o   <= 1'b0;
            sad_enb_o <= 1'b1;
            sad_dta_o <= a0;
            sad_dtb_o <= b0;
            idx       <= '0;
            tcnt      <= '0;
            shadow    <= '0;
            mism_o    <= 1'b0;
            err_o     <= 1'b0;
          end
        end
        ISSUE: begin
          sad_enb_o <= 1'b0;
          shadow    <= shadow + {{(RW-DW-1){1'b0}}, diff};
          idx       <= nidx;
          sad_dta_o <= mem_a[nidx];
          sad_dtb_o <= mem_b[nidx];
          state     <= STREAM;
        end
        STREAM: begin
          shadow <= shadow + {{(RW-DW-1){1'b0}}, diff};
          if (idx == AW'(N_SAMPLES - 1)) begin
            sad_dta_o <= '0;
            sad_dtb_o <= '0;
            state     <= WAIT;
          end else begin
            idx       <= nidx;
            sad_dta_o <= mem_a[nidx];
            sad_dtb_o <= mem_b[nidx];
          end
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (!sad_busy_i) begin
            res_data_o  <= sad_dt_i;
            mism_o      <= (sad_dt_i != shadow);
            res_valid_o <= 1'b1;
            state       <= HOLD;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            res_data_o  <= '0;
            mism_o      <= 1'b0;
            err_o       <= 1'b1;
            res_valid_o <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            ready_o     <= 1'b1;
            idx         <= '0;
            tcnt        <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_stream_driver.sv
// Scoreboard bench for sad_stream_driver with a behavioural SAD engine on the far side.
module tb_sad_stream_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_sel;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start_i;
  logic        ready_o, sad_enb_o;
  logic [7:0]  sad_dta_o, sad_dtb_o;
  logic        sad_busy_i;
  logic [31:0] sad_dt_i;
  logic        res_valid_o, res_ready_i, mism_o, err_o;
  logic [31:0] res_data_o;

  typedef struct packed { logic [31:0] d; logic m; logic e; } exp_t;
  typedef struct packed { logic enb; logic [7:0] a; logic [7:0] b; } pair_t;

  exp_t        sb[$];
  pair_t       plog[$];
  logic [7:0]  ma [16];
  logic [7:0]  mb [16];
  logic [31:0] bias = '0;
  logic        stuck = 1'b0;
  int          total = 0;
  int          bad = 0;

  sad_stream_driver dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start_i(start_i), .ready_o(ready_o), .sad_enb_o(sad_enb_o),
    .sad_dta_o(sad_dta_o), .sad_dtb_o(sad_dtb_o), .sad_busy_i(sad_busy_i),
    .sad_dt_i(sad_dt_i), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_ready_i(res_ready_i), .mism_o(mism_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Engine model: sums 16 pairs from the enb pulse, drops busy 2 cycles later.
  int          ecnt = 0;
  int          epost = 0;
  logic [31:0] eacc = '0;
  initial begin
    sad_busy_i = 1'b0;
    sad_dt_i   = '0;
  end
  always @(negedge clk) begin
    if (rst) begin
      ecnt = 0; epost = 0; eacc = '0; sad_busy_i = 1'b0;
    end else if (sad_enb_o) begin
      eacc = (sad_dta_o > sad_dtb_o) ? 32'(sad_dta_o - sad_dtb_o) : 32'(sad_dtb_o - sad_dta_o);
      ecnt = 1; epost = 0; sad_busy_i = 1'b1;
      plog.push_back({sad_enb_o, sad_dta_o, sad_dtb_o});
    end else if (ecnt > 0 && ecnt < 16) begin
      eacc += (sad_dta_o > sad_dtb_o) ? 32'(sad_dta_o - sad_dtb_o) : 32'(sad_dtb_o - sad_dta_o);
      ecnt++;
      plog.push_back({sad_enb_o, sad_dta_o, sad_dtb_o});
    end else if (ecnt == 16) begin
      if (epost < 2) epost++;
      if (epost == 2 && !stuck) sad_busy_i = 1'b0;
    end
    sad_dt_i = eacc + bias;
  end

  function automatic logic [31:0] model_sad();
    logic [31:0] s = '0;
    for (int i = 0; i < 16; i++)
      s += (ma[i] > mb[i]) ? 32'(ma[i] - mb[i]) : 32'(mb[i] - ma[i]);
    return s;
  endfunction

  task automatic do_write(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) begin
      do_write(1'b0, 4'(i), ma[i]);
      do_write(1'b1, 4'(i), mb[i]);
    end
  endtask

  task automatic start_run(input logic [31:0] d, input logic m, input logic e);
    sb.push_back({d, m, e});
    plog.delete();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic get_res(output logic [31:0] d, output logic m, output logic e, output logic ok);
    ok = 1'b0; d = '0; m = 1'b0; e = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (res_valid_o) begin
        ok = 1'b1; d = res_data_o; m = mism_o; e = err_o;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept();
    @(negedge clk);
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    total++; if (sad_enb_o !== 1'b0) begin bad++; $display("FAIL reset_enb got=%b want=0", sad_enb_o); end
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", res_valid_o); end
    total++; if ({mism_o, err_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {mism_o, err_o}); end
    total++; if ({res_data_o, sad_dta_o, sad_dtb_o} !== '0) begin bad++; $display("FAIL reset_data got=%h/%h/%h want=0", res_data_o, sad_dta_o, sad_dtb_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] d; logic m, e, ok; exp_t x;
    for (int i = 0; i < 16; i++) begin ma[i] = 8'd24; mb[i] = 8'd32; end
    load_all();
    bias = '0;
    start_run(model_sad(), 1'b0, 1'b0);
    get_res(d, m, e, ok);
    x = sb.pop_front();
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=no_valid want=valid"); end
    total++; if (d !== x.d || d !== 32'd128) begin bad++; $display("FAIL basic_data got=%0d want=%0d", d, x.d); end
    total++; if ({m, e} !== {x.m, x.e}) begin bad++; $display("FAIL basic_flags got=%b want=%b", {m, e}, {x.m, x.e}); end
    total++; if (plog.size() != 16) begin bad++; $display("FAIL basic_pairs got=%0d want=16", plog.size()); end
    for (int i = 0; i < 16 && i < plog.size(); i++) begin
      total++;
      if (plog[i] !== {(i == 0), ma[i], mb[i]}) begin
        bad++; $display("FAIL basic_pair%0d got=%h want=%h", i, plog[i], {(i == 0), ma[i], mb[i]});
      end
    end
    accept();
    total++; if ({ready_o, res_valid_o} !== 2'b10) begin bad++; $display("FAIL basic_accept got=%b want=10", {ready_o, res_valid_o}); end
  endtask

  task automatic test_pattern();
    logic [31:0] d; logic m, e, ok; exp_t x;
    for (int i = 0; i < 16; i++) begin ma[i] = 8'(i * 16); mb[i] = 8'(255 - i * 16); end
    load_all();
    for (int r = 0; r < 2; r++) begin
      bias = (r == 0) ? 32'd0 : 32'hFFFF_FFFF;
      start_run(model_sad() + bias, (r == 1), 1'b0);
      get_res(d, m, e, ok);
      x = sb.pop_front();
      total++; if (!ok || d !== x.d || d !== (r == 0 ? 32'd2048 : 32'd2047)) begin bad++; $display("FAIL pattern%0d_data got=%0d want=%0d", r, d, x.d); end
      total++; if ({m, e} !== {x.m, x.e}) begin bad++; $display("FAIL pattern%0d_flags got=%b want=%b", r, {m, e}, {x.m, x.e}); end
      accept();
    end
    bias = '0;
  endtask

  task automatic test_timeout();
    logic [31:0] d; logic m, e, ok; exp_t x;
    stuck = 1'b1;
    start_run(32'd0, 1'b0, 1'b1);
    get_res(d, m, e, ok);
    x = sb.pop_front();
    total++; if (!ok) begin bad++; $display("FAIL timeout_valid got=no_valid want=valid"); end
    total++; if ({d, m, e} !== {x.d, x.m, x.e}) begin bad++; $display("FAIL timeout_res got=%0d/%b/%b want=%0d/%b/%b", d, m, e, x.d, x.m, x.e); end
    accept();
    stuck = 1'b0;
  endtask

  task automatic test_hold();
    logic [31:0] d; logic m, e, ok; exp_t x;
    start_run(model_sad(), 1'b0, 1'b0);
    get_res(d, m, e, ok);
    x = sb.pop_front();
    total++; if (!ok || d !== x.d) begin bad++; $display("FAIL hold_first got=%0d want=%0d", d, x.d); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (res_valid_o !== 1'b1 || res_data_o !== x.d || ready_o !== 1'b0 || sad_enb_o !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d got=v%b d%0d r%b e%b want=v1 d%0d r0 e0", i, res_valid_o, res_data_o, ready_o, sad_enb_o, x.d);
      end
      start_i = i[0]; wr_en = 1'b1; wr_sel = i[1]; wr_addr = 4'(i); wr_data = 8'd77;
    end
    @(negedge clk);
    start_i = 1'b0; wr_en = 1'b0;
    total++; if (plog.size() != 16) begin bad++; $display("FAIL hold_nostream got=%0d want=16", plog.size()); end
    accept();
    total++; if ({ready_o, res_valid_o} !== 2'b10) begin bad++; $display("FAIL hold_release got=%b want=10", {ready_o, res_valid_o}); end
    start_run(model_sad(), 1'b0, 1'b0);
    get_res(d, m, e, ok);
    x = sb.pop_front();
    total++; if (!ok || {d, m, e} !== {x.d, x.m, x.e}) begin bad++; $display("FAIL hold_memkept got=%0d/%b/%b want=%0d/%b/%b", d, m, e, x.d, x.m, x.e); end
    accept();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic m, e, ok; exp_t x;
    for (int i = 0; i < 16; i++) begin ma[i] = 8'($urandom_range(0, 255)); mb[i] = 8'($urandom_range(0, 255)); end
    load_all();
    start_run(model_sad(), 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({ready_o, sad_enb_o, res_valid_o} !== 3'b100) begin bad++; $display("FAIL midreset got=%b want=100", {ready_o, sad_enb_o, res_valid_o}); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    start_run(model_sad(), 1'b0, 1'b0);
    get_res(d, m, e, ok);
    x = sb.pop_front();
    total++; if (!ok || {d, m, e} !== {x.d, x.m, x.e}) begin bad++; $display("FAIL midreset_rerun got=%0d/%b/%b want=%0d/%b/%b", d, m, e, x.d, x.m, x.e); end
    total++; if (plog.size() != 16) begin bad++; $display("FAIL midreset_pairs got=%0d want=16", plog.size()); end
    accept();
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic m, e, ok; exp_t x;
    do_write(1'b1, 4'd0, 8'd0);
    mb[0] = 8'd0;
    ma[0] = 8'd200;
    sb.push_back({model_sad(), 1'b0, 1'b0});
    plog.delete();
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd200; start_i = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start_i = 1'b0;
    get_res(d, m, e, ok);
    x = sb.pop_front();
    total++; if (plog.size() == 0 || plog[0] !== {1'b1, 8'd200, 8'd0}) begin bad++; $display("FAIL samecycle_first got=%h want=%h", (plog.size() > 0) ? plog[0] : 17'h0, {1'b1, 8'd200, 8'd0}); end
    total++; if (!ok || {d, m, e} !== {x.d, x.m, x.e}) begin bad++; $display("FAIL samecycle_res got=%0d/%b/%b want=%0d/%b/%b", d, m, e, x.d, x.m, x.e); end
    accept();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start_i = 1'b0; res_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_pattern();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_same_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sad_stream_driver.md
Name: sad_stream_driver

Overview:
- Initiator-side companion to the sad engine.
- Holds two N-sample operand blocks (A and B), loaded by a host write port.
- On start, streams sample pairs into the engine (enb, dta, dtb), waits for the engine's busy to fall, then captures its 32-bit sum.
- Computes its own shadow SAD in parallel and flags any mismatch. Returns the result to the host on a valid/ready handshake.

Parameters:
- N_SAMPLES, 16, samples per block (power of two, 2..256)
- DW, 8, sample width (unsigned)
- RW, 32, result width
- AW, 4, sample address width (log2 N_SAMPLES)
- TIMEOUT, 64, max cycles in WAIT before error

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write strobe for operand memory
- wr_sel  in  1  0 = block A, 1 = block B
- wr_addr  in  AW  sample index
- wr_data  in  DW  sample value
- start_i  in  1  begin transfer (sampled only in IDLE)
- ready_o  out  1  high only in IDLE
- sad_enb_o  out  1  one-cycle start pulse to engine
- sad_dta_o  out  DW  A sample to engine
- sad_dtb_o  out  DW  B sample to engine
- sad_busy_i  in  1  engine busy
- sad_dt_i  in  RW  engine accumulated sum
- res_valid_o  out  1  result available
- res_data_o  out  RW  captured engine sum
- res_ready_i  in  1  host accepts result
- mism_o  out  1  engine sum != shadow sum (valid with res_valid_o)
- err_o  out  1  timeout occurred (valid with res_valid_o)

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; ready_o=1; all other outputs 0; index and timeout counters 0.
  - Operand memory contents are not cleared.
  - Reset overrides any state, including mid-stream; sad_enb_o drops the same edge.
- Writes: wr_en honoured only in IDLE. Ignored in all other states with no side effect. Write and start in the same IDLE cycle: write lands first, and the streamed data uses the new value.
- State IDLE: start_i=1 -> ISSUE next cycle. Shadow accumulator, mism and err are cleared on this edge.
- State ISSUE (1 cycle):
  - sad_enb_o=1, dta=A[0], dtb=B[0].
  - Shadow += |A[0]-B[0]|.
  - Next state STREAM with idx=1.
- State STREAM:
  - Per cycle: dta=A[idx], dtb=B[idx], sad_enb_o=0; shadow += |A[idx]-B[idx]|; idx++.
  - After idx=N_SAMPLES-1 is presented, go to WAIT.
  - Total: exactly N_SAMPLES consecutive pair cycles starting at ISSUE.
- State WAIT:
  - dta/dtb hold 0. The timeout counter increments each cycle.
  - sad_busy_i=0 -> capture: res_data_o<=sad_dt_i, mism_o<=(sad_dt_i != shadow), go HOLD.
  - Counter reaches TIMEOUT with busy still 1 -> res_data_o<=0, err_o<=1, mism_o<=0, go HOLD.
  - Busy already low on the first WAIT cycle is a legal capture (minimum WAIT length 1).
- State HOLD:
  - res_valid_o=1; res_data_o, mism_o and err_o stable.
  - res_ready_i=1 -> IDLE next cycle (res_valid_o falls the same edge).
  - start_i is ignored in HOLD.
- Arithmetic:
  - |a-b| is computed at DW+1 bits, then zero-extended into an RW-bit shadow accumulator.
  - The accumulator wraps modulo 2^RW; no saturation.
- Latency: start_i edge to first res_valid_o = 1 (ISSUE) + N_SAMPLES-1 (STREAM) + WAIT cycles + 1.
- ready_o=1 only in IDLE; start_i in any other state is dropped (not queued).

Test Plan:
- Load A[i]=24, B[i]=32 for all 16 samples, start, engine model drops busy 2 cycles after the last sample -> 16 pair cycles with enb high only on the first; res_data_o=128, mism_o=0, err_o=0.
- A[i]=i*16, B[i]=255-i*16 -> shadow=Σ|32i-255| (i=0..15)=2048; engine model returns 2048 -> mism_o=0. Rerun with the model returning 2047 -> mism_o=1, res_data_o=2047.
- Engine holds busy high forever -> after TIMEOUT=64 WAIT cycles: res_valid_o=1, err_o=1, res_data_o=0.
- Hold res_ready_i=0 for 10 cycles while pulsing start_i and wr_en -> res_valid_o stays 1 with data unchanged; memory unchanged; no second transfer. Raise res_ready_i -> IDLE, ready_o=1 next cycle.
- Assert rst at STREAM idx=7 -> next cycle ready_o=1, sad_enb_o=0, res_valid_o=0. A new start reruns a full 16-pair stream with correct result.
- Same-cycle wr_en (A[0]=200, B[0]=0) and start_i -> first pair on the bus is dta=200, dtb=0.
